ast_upsizer: RTL and testbench

AST_UPSIZER -- requirements
Module: ast_upsizer

---
 rtl/ast_upsizer_pkg.sv | 27 ++
 rtl/ast_upsizer_out_reg.sv | 35 +++
 rtl/ast_upsizer.sv | 171 +++++++++++++++++
 tb/tb_ast_upsizer.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ast_upsizer_pkg.sv
// rtl/ast_upsizer_pkg.sv - shared widths, field types and FSM states for the stream upsizer
package ast_upsizer_pkg;

    localparam int DATA_IN_W_DEF  = 64;
    localparam int DATA_OUT_W_DEF = 128;
    localparam int CHANNEL_W_DEF  = 10;

    function automatic int empty_w(input int width);
        return ((width / 8) > 1) ? $clog2(width / 8) : 1;
    endfunction

    localparam int EMPTY_IN_W_DEF  = empty_w(DATA_IN_W_DEF);
    localparam int EMPTY_OUT_W_DEF = empty_w(DATA_OUT_W_DEF);
    localparam int RATIO_DEF       = DATA_OUT_W_DEF / DATA_IN_W_DEF;

    typedef logic [DATA_IN_W_DEF-1:0]   data_in_t;
    typedef logic [DATA_OUT_W_DEF-1:0]  data_out_t;
    typedef logic [CHANNEL_W_DEF-1:0]   channel_t;
    typedef logic [EMPTY_IN_W_DEF-1:0]  empty_in_t;
    typedef logic [EMPTY_OUT_W_DEF-1:0] empty_out_t;

    typedef enum logic {
        IDLE,
        PKT
    } state_t;

endpackage

// File: rtl/ast_upsizer_out_reg.sv
// rtl/ast_upsizer_out_reg.sv - one-entry output register with valid/ready handshake
module ast_upsizer_out_reg #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         srst_i,
    input  logic [W-1:0] in_tdata,
    input  logic         in_tvalid,
    output logic         in_tready,
    output logic [W-1:0] out_tdata,
    output logic         out_tvalid,
    input  logic         out_tready
);

    logic         valid_q;
    logic [W-1:0] data_q;

    // A new entry may be loaded in the same cycle the current one drains.
    assign in_tready  = !valid_q || out_tready;
    assign out_tdata  = data_q;
    assign out_tvalid = valid_q;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (in_tvalid && in_tready) begin
            valid_q <= 1'b1;
            data_q  <= in_tdata;
        end else if (out_tready) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/ast_upsizer.sv
// rtl/ast_upsizer.sv - packs narrow packet beats little-endian into wide output words
// Define AST_UPSIZER_PROT_CHK_EN to close packets on a stray sop and flag it on ast_error_o.
module ast_upsizer
    import ast_upsizer_pkg::*;
#(
    parameter int DATA_IN_W   = DATA_IN_W_DEF,
    parameter int DATA_OUT_W  = DATA_OUT_W_DEF,
    parameter int CHANNEL_W   = CHANNEL_W_DEF,
    parameter int EMPTY_IN_W  = empty_w(DATA_IN_W),
    parameter int EMPTY_OUT_W = empty_w(DATA_OUT_W)
) (
    input  logic                   clk_i,
    input  logic                   srst_i,
    input  logic [DATA_IN_W-1:0]   ast_data_i,
    input  logic                   ast_startofpacket_i,
    input  logic                   ast_endofpacket_i,
    input  logic                   ast_valid_i,
    input  logic [EMPTY_IN_W-1:0]  ast_empty_i,
    input  logic [CHANNEL_W-1:0]   ast_channel_i,
    output logic                   ast_ready_o,
    output logic [DATA_OUT_W-1:0]  ast_data_o,
    output logic                   ast_startofpacket_o,
    output logic                   ast_endofpacket_o,
    output logic                   ast_valid_o,
    output logic [EMPTY_OUT_W-1:0] ast_empty_o,
    output logic [CHANNEL_W-1:0]   ast_channel_o,
    input  logic                   ast_ready_i
`ifdef AST_UPSIZER_PROT_CHK_EN
    ,
    output logic                   ast_error_o
`endif
);

    localparam int N     = DATA_OUT_W / DATA_IN_W;
    localparam int BYTES = DATA_IN_W / 8;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int PW    = 2 + EMPTY_OUT_W + CHANNEL_W + DATA_OUT_W;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d, lane;
    logic [DATA_OUT_W-1:0]  acc_q, acc_d, word;
    logic [CHANNEL_W-1:0]   chan_q, chan_d, word_chan;
    logic [EMPTY_OUT_W-1:0] word_empty, pend_empty_q, pend_empty_d;
    logic                   first_q, first_d, pend_q, pend_d;
    logic                   restart, close, start, take, completes, word_sop, accept;
    logic                   push_valid, push_ready;
    logic [PW-1:0]          push_data, out_data;

    // Beat decode depends only on inputs and state, so ready can be derived from it.
    always_comb begin
        restart = 1'b0;
        close   = 1'b0;
`ifdef AST_UPSIZER_PROT_CHK_EN
        restart = (state_q == PKT) && ast_startofpacket_i;
        close   = restart && (cnt_q != '0);
`endif
        start      = ast_startofpacket_i && ((state_q == IDLE) || restart);
        take       = (state_q == PKT) || start;
        lane       = start ? '0 : cnt_q;
        completes  = take && (ast_endofpacket_i || (lane == LAST));
        word       = (start ? '0 : acc_q) | (DATA_OUT_W'(ast_data_i) << (int'(lane) * DATA_IN_W));
        word_empty = '0;
        if (ast_endofpacket_i) begin
            word_empty = EMPTY_OUT_W'((N - 1 - int'(lane)) * BYTES) + EMPTY_OUT_W'(ast_empty_i);
        end
        word_chan  = start ? ast_channel_i : chan_q;
        word_sop   = start || first_q;
    end

    // Stall only when this beat must push a word and the output register cannot take it.
    assign ast_ready_o = !srst_i && !pend_q && !((close || completes) && !push_ready);
    assign accept      = ast_valid_i && ast_ready_o;

    always_comb begin
        push_valid   = 1'b0;
        push_data    = {word_sop, ast_endofpacket_i, word_empty, word_chan, word};
        state_d      = state_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        chan_d       = chan_q;
        first_d      = first_q;
        pend_d       = pend_q;
        pend_empty_d = pend_empty_q;
        if (pend_q) begin
            push_valid = 1'b1;
            push_data  = {1'b1, 1'b1, pend_empty_q, chan_q, acc_q};
            if (push_ready) begin
                pend_d = 1'b0;
                acc_d  = '0;
            end
        end else if (accept && take) begin
            if (close) begin
                push_valid = 1'b1;
                push_data  = {first_q, 1'b1, EMPTY_OUT_W'((N - int'(cnt_q)) * BYTES), chan_q, acc_q};
            end else begin
                push_valid = completes;
            end
            if (start) begin
                chan_d = ast_channel_i;
            end
            if (completes) begin
                cnt_d   = '0;
                acc_d   = '0;
                first_d = 1'b0;
                state_d = ast_endofpacket_i ? IDLE : PKT;
                // A single-beat packet behind a forced close waits one cycle in the accumulator.
                if (close) begin
                    pend_d       = 1'b1;
                    acc_d        = word;
                    pend_empty_d = word_empty;
                end
            end else begin
                cnt_d   = lane + 1'b1;
                acc_d   = word;
                first_d = word_sop;
                state_d = PKT;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            acc_q        <= '0;
            chan_q       <= '0;
            first_q      <= 1'b0;
            pend_q       <= 1'b0;
            pend_empty_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            chan_q       <= chan_d;
            first_q      <= first_d;
            pend_q       <= pend_d;
            pend_empty_q <= pend_empty_d;
        end
    end

`ifdef AST_UPSIZER_PROT_CHK_EN
    logic err_q;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= accept && restart;
        end
    end

    assign ast_error_o = err_q;
`endif

    ast_upsizer_out_reg #(
        .W(PW)
    ) u_out_reg (
        .clk_i     (clk_i),
        .srst_i    (srst_i),
        .in_tdata  (push_data),
        .in_tvalid (push_valid),
        .in_tready (push_ready),
        .out_tdata (out_data),
        .out_tvalid(ast_valid_o),
        .out_tready(ast_ready_i)
    );

    assign {ast_startofpacket_o, ast_endofpacket_o, ast_empty_o, ast_channel_o, ast_data_o} = out_data;

endmodule

// File: tb/tb_ast_upsizer.sv
// tb/tb_ast_upsizer.sv - self-checking bench for ast_upsizer with a packet-level reference model
`timescale 1ns/1ps
module tb_ast_upsizer;
    import ast_upsizer_pkg::*;

    localparam int N     = RATIO_DEF;
    localparam int IN_W  = DATA_IN_W_DEF;
    localparam int BYTES = IN_W / 8;

    typedef struct packed {
        logic      sop;
        logic      eop;
        empty_in_t empty;
        channel_t  chan;
        data_in_t  data;
    } beat_t;

    typedef struct packed {
        logic       sop;
        logic       eop;
        empty_out_t empty;
        channel_t   chan;
        data_out_t  data;
    } word_t;

    logic       clk = 1'b0;
    logic       srst_i;
    data_in_t   ast_data_i;
    logic       ast_startofpacket_i, ast_endofpacket_i, ast_valid_i;
    empty_in_t  ast_empty_i;
    channel_t   ast_channel_i;
    logic       ast_ready_o;
    data_out_t  ast_data_o;
    logic       ast_startofpacket_o, ast_endofpacket_o, ast_valid_o;
    empty_out_t ast_empty_o;
    channel_t   ast_channel_o;
    logic       ast_ready_i;
`ifdef AST_UPSIZER_PROT_CHK_EN
    logic       ast_error_o;
`endif

    int    checks = 0;
    int    errors = 0;
    int    last_stall = 0;
    int    err_pulses = 0;
    bit    rand_rdy = 1'b0;
    beat_t beats_q[$];
    word_t words_q[$];
    word_t exp_q[$];
    word_t out_word;

    always #5 clk = ~clk;

    ast_upsizer dut (
        .clk_i              (clk),
        .srst_i             (srst_i),
        .ast_data_i         (ast_data_i),
        .ast_startofpacket_i(ast_startofpacket_i),
        .ast_endofpacket_i  (ast_endofpacket_i),
        .ast_valid_i        (ast_valid_i),
        .ast_empty_i        (ast_empty_i),
        .ast_channel_i      (ast_channel_i),
        .ast_ready_o        (ast_ready_o),
        .ast_data_o         (ast_data_o),
        .ast_startofpacket_o(ast_startofpacket_o),
        .ast_endofpacket_o  (ast_endofpacket_o),
        .ast_valid_o        (ast_valid_o),
        .ast_empty_o        (ast_empty_o),
        .ast_channel_o      (ast_channel_o),
        .ast_ready_i        (ast_ready_i)
`ifdef AST_UPSIZER_PROT_CHK_EN
        ,
        .ast_error_o        (ast_error_o)
`endif
    );

    assign out_word = word_t'({ast_startofpacket_o, ast_endofpacket_o, ast_empty_o, ast_channel_o, ast_data_o});

    always @(negedge clk) begin
        if (ast_valid_i && ast_ready_o)
            beats_q.push_back(beat_t'({ast_startofpacket_i, ast_endofpacket_i, ast_empty_i, ast_channel_i, ast_data_i}));
        if (ast_valid_o && ast_ready_i)
            words_q.push_back(out_word);
`ifdef AST_UPSIZER_PROT_CHK_EN
        if (ast_error_o)
            err_pulses++;
`endif
    end

    // Packet-level model: group accepted beats into packets, cut each into N-beat words.
    function automatic void build_model();
        bit        open = 1'b0;
        int        k = 0;
        data_out_t acc = '0;
        bit        first = 1'b0;
        channel_t  ch = '0;
        exp_q.delete();
        foreach (beats_q[i]) begin
            beat_t b;
            b = beats_q[i];
`ifdef AST_UPSIZER_PROT_CHK_EN
            if (open && b.sop) begin
                if (k > 0)
                    exp_q.push_back(word_t'({first, 1'b1, empty_out_t'((N - k) * BYTES), ch, acc}));
                open = 1'b0;
            end
`endif
            if (!open) begin
                if (!b.sop)
                    continue;
                open  = 1'b1;
                k     = 0;
                acc   = '0;
                first = 1'b1;
                ch    = b.chan;
            end
            acc[k*IN_W +: IN_W] = b.data;
            k++;
            if (b.eop || k == N) begin
                exp_q.push_back(word_t'({first, b.eop,
                    b.eop ? empty_out_t'((N - k) * BYTES + int'(b.empty)) : empty_out_t'(0), ch, acc}));
                first = 1'b0;
                acc   = '0;
                k     = 0;
                if (b.eop)
                    open = 1'b0;
            end
        end
    endfunction

    task automatic send(input logic sop, input logic eop, input data_in_t d, input empty_in_t e, input channel_t c);
        int n = 0;
        ast_valid_i         = 1'b1;
        ast_startofpacket_i = sop;
        ast_endofpacket_i   = eop;
        ast_data_i          = d;
        ast_empty_i         = e;
        ast_channel_i       = c;
        forever begin
            @(negedge clk);
            if (ast_ready_o)
                break;
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: ready_o stayed %b, required 1", ast_ready_o);
                break;
            end
            @(posedge clk); #1;
            if (rand_rdy)
                ast_ready_i = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        ast_valid_i = 1'b0;
        if (rand_rdy)
            ast_ready_i = ($urandom_range(0, 3) != 0);
        last_stall = n;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            if (rand_rdy)
                ast_ready_i = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic test_reset();
        srst_i              = 1'b1;
        ast_valid_i         = 1'b1;
        ast_startofpacket_i = 1'b1;
        ast_endofpacket_i   = 1'b0;
        ast_data_i          = '1;
        ast_empty_i         = '0;
        ast_channel_i       = '1;
        ast_ready_i         = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (ast_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, required 0", ast_valid_o); end
        checks++; if (ast_startofpacket_o !== 1'b0) begin errors++; $display("FAIL rst_sop: got %b, required 0", ast_startofpacket_o); end
        checks++; if (ast_endofpacket_o !== 1'b0) begin errors++; $display("FAIL rst_eop: got %b, required 0", ast_endofpacket_o); end
        checks++; if (ast_empty_o !== '0) begin errors++; $display("FAIL rst_empty: got %0d, required 0", ast_empty_o); end
        checks++; if (ast_data_o !== '0) begin errors++; $display("FAIL rst_data: got %h, required 0", ast_data_o); end
        checks++; if (ast_channel_o !== '0) begin errors++; $display("FAIL rst_channel: got %0d, required 0", ast_channel_o); end
        checks++; if (ast_ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b, required 0", ast_ready_o); end
        @(posedge clk); #1;
        srst_i      = 1'b0;
        ast_valid_i = 1'b0;
        @(negedge clk);
        checks++; if (ast_ready_o !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b, required 1", ast_ready_o); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        data_out_t exp_data;
        ast_ready_i = 1'b1;
        send(1'b1, 1'b0, 64'h11, 3'd0, 10'd5);
        checks++; if (ast_valid_o !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b, required 0", ast_valid_o); end
        send(1'b0, 1'b1, 64'h22, 3'd0, 10'd7);
        exp_data = {64'h22, 64'h11};
        checks++; if (ast_valid_o !== 1'b1) begin errors++; $display("FAIL basic_latency: valid %b, required 1", ast_valid_o); end
        checks++; if (ast_data_o !== exp_data) begin errors++; $display("FAIL basic_data: got %h, required %h", ast_data_o, exp_data); end
        checks++; if ({ast_startofpacket_o, ast_endofpacket_o} !== 2'b11) begin errors++; $display("FAIL basic_flags: got %b, required 11", {ast_startofpacket_o, ast_endofpacket_o}); end
        checks++; if (ast_empty_o !== 4'd0) begin errors++; $display("FAIL basic_empty: got %0d, required 0", ast_empty_o); end
        checks++; if (ast_channel_o !== 10'd5) begin errors++; $display("FAIL basic_channel: got %0d, required 5", ast_channel_o); end
        send(1'b1, 1'b1, 64'hAA, 3'd3, 10'd2);
        exp_data = {64'h0, 64'hAA};
        checks++; if (ast_data_o !== exp_data) begin errors++; $display("FAIL single_data: got %h, required %h", ast_data_o, exp_data); end
        checks++; if (ast_empty_o !== 4'd11) begin errors++; $display("FAIL single_empty: got %0d, required 11", ast_empty_o); end
        checks++; if ({ast_startofpacket_o, ast_endofpacket_o} !== 2'b11) begin errors++; $display("FAIL single_flags: got %b, required 11", {ast_startofpacket_o, ast_endofpacket_o}); end
        idle(2);
    endtask

    task automatic test_back_to_back();
        empty_in_t e = empty_in_t'($urandom());
        channel_t  c = channel_t'($urandom());
        beats_q.delete();
        words_q.delete();
        ast_ready_i = 1'b1;
        for (int j = 0; j < 5; j++) begin
            send(j == 0, j == 4, data_in_t'({$urandom(), $urandom()}), e, c);
            checks++; if (last_stall !== 0) begin errors++; $display("FAIL b2b_stall[%0d]: stalled %0d cycles, required 0", j, last_stall); end
        end
        idle(3);
        build_model();
        checks++; if (words_q.size() !== 3) begin errors++; $display("FAIL b2b_count: got %0d words, required 3", words_q.size()); end
        if (words_q.size() == 3) begin
            checks++; if (words_q[2].empty !== empty_out_t'(8 + int'(e))) begin errors++; $display("FAIL b2b_last_empty: got %0d, required %0d", words_q[2].empty, 8 + int'(e)); end
        end
        for (int i = 0; i < exp_q.size() && i < words_q.size(); i++) begin
            checks++; if (words_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_word[%0d]: got %h, required %h", i, words_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_backpressure();
        data_in_t  b0 = data_in_t'({$urandom(), $urandom()});
        data_in_t  b1 = data_in_t'({$urandom(), $urandom()});
        data_in_t  b2 = data_in_t'({$urandom(), $urandom()});
        data_in_t  b3 = data_in_t'({$urandom(), $urandom()});
        channel_t  c  = channel_t'($urandom());
        empty_in_t e3 = empty_in_t'($urandom());
        word_t     w1, w2;
        w1 = word_t'({1'b1, 1'b0, empty_out_t'(0), c, b1, b0});
        w2 = word_t'({1'b0, 1'b1, empty_out_t'(e3), c, b3, b2});
        words_q.delete();
        ast_ready_i = 1'b1;
        send(1'b1, 1'b0, b0, '0, c);
        send(1'b0, 1'b0, b1, '0, c);
        ast_ready_i         = 1'b0;
        ast_valid_i         = 1'b1;
        ast_startofpacket_i = 1'b0;
        ast_endofpacket_i   = 1'b0;
        ast_data_i          = b2;
        ast_empty_i         = '0;
        @(negedge clk);
        checks++; if (ast_ready_o !== 1'b1) begin errors++; $display("FAIL bp_ready_partial: got %b, required 1", ast_ready_o); end
        @(posedge clk); #1;
        ast_endofpacket_i = 1'b1;
        ast_data_i        = b3;
        ast_empty_i       = e3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (ast_ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready_stall[%0d]: got %b, required 0", i, ast_ready_o); end
            checks++; if (!ast_valid_o || out_word !== w1) begin errors++; $display("FAIL bp_hold[%0d]: valid %b word %h, required %h", i, ast_valid_o, out_word, w1); end
            @(posedge clk); #1;
        end
        ast_ready_i = 1'b1;
        @(negedge clk);
        checks++; if (ast_ready_o !== 1'b1) begin errors++; $display("FAIL bp_ready_resume: got %b, required 1", ast_ready_o); end
        @(posedge clk); #1;
        ast_valid_i = 1'b0;
        idle(2);
        checks++; if (words_q.size() !== 2) begin errors++; $display("FAIL bp_count: got %0d words, required 2", words_q.size()); end
        if (words_q.size() == 2) begin
            checks++; if (words_q[0] !== w1) begin errors++; $display("FAIL bp_word1: got %h, required %h", words_q[0], w1); end
            checks++; if (words_q[1] !== w2) begin errors++; $display("FAIL bp_word2: got %h, required %h", words_q[1], w2); end
        end
    endtask

    task automatic test_mid_reset();
        data_in_t x = 64'h0123_4567_89AB_CDEF;
        data_in_t y = 64'hFEDC_BA98_7654_3210;
        word_t    w;
        w = word_t'({1'b1, 1'b1, empty_out_t'(2), channel_t'(9), y, x});
        ast_ready_i = 1'b0;
        send(1'b1, 1'b0, data_in_t'($urandom()), '0, 10'd1);
        send(1'b0, 1'b0, data_in_t'($urandom()), '0, 10'd1);
        send(1'b0, 1'b0, data_in_t'($urandom()), '0, 10'd1);
        words_q.delete();
        srst_i = 1'b1;
        @(posedge clk); #1;
        ast_ready_i = 1'b1;
        @(posedge clk); #1;
        srst_i = 1'b0;
        @(negedge clk);
        checks++; if (ast_ready_o !== 1'b1) begin errors++; $display("FAIL mrst_ready: got %b, required 1", ast_ready_o); end
        @(posedge clk); #1;
        idle(2);
        checks++; if (words_q.size() !== 0) begin errors++; $display("FAIL mrst_no_output: got %0d words, required 0", words_q.size()); end
        send(1'b1, 1'b0, x, '0, 10'd9);
        send(1'b0, 1'b1, y, 3'd2, 10'd4);
        idle(2);
        checks++; if (words_q.size() !== 1) begin errors++; $display("FAIL mrst_count: got %0d words, required 1", words_q.size()); end
        if (words_q.size() == 1) begin
            checks++; if (words_q[0] !== w) begin errors++; $display("FAIL mrst_word: got %h, required %h", words_q[0], w); end
        end
    endtask

    task automatic test_random();
        beats_q.delete();
        words_q.delete();
        rand_rdy = 1'b1;
        for (int p = 0; p < 40; p++) begin
            int       len = $urandom_range(1, 7);
            channel_t ch  = channel_t'($urandom());
            if ($urandom_range(0, 3) == 0)
                send(1'b0, 1'($urandom_range(0, 1)), data_in_t'({$urandom(), $urandom()}), empty_in_t'($urandom()), channel_t'($urandom()));
            for (int j = 0; j < len; j++)
                send(j == 0, j == len - 1, data_in_t'({$urandom(), $urandom()}), empty_in_t'($urandom()),
                     (j == 0) ? ch : channel_t'($urandom()));
            if ($urandom_range(0, 1) == 1)
                idle($urandom_range(1, 3));
        end
        rand_rdy    = 1'b0;
        ast_ready_i = 1'b1;
        idle(4);
        build_model();
        checks++; if (words_q.size() !== exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d words, required %0d", words_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < words_q.size(); i++) begin
            checks++; if (words_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_word[%0d]: got %h, required %h", i, words_q[i], exp_q[i]); end
        end
    endtask

`ifdef AST_UPSIZER_PROT_CHK_EN
    task automatic test_prot_chk();
        data_in_t  a = data_in_t'({$urandom(), $urandom()});
        data_in_t  b = data_in_t'({$urandom(), $urandom()});
        data_in_t  d = data_in_t'({$urandom(), $urandom()});
        empty_in_t e = empty_in_t'($urandom());
        word_t     w1, w2;
        w1 = word_t'({1'b1, 1'b1, empty_out_t'(8), channel_t'(3), 64'h0, a});
        w2 = word_t'({1'b1, 1'b1, empty_out_t'(e), channel_t'(7), d, b});
        words_q.delete();
        err_pulses  = 0;
        ast_ready_i = 1'b1;
        send(1'b1, 1'b0, a, '0, 10'd3);
        send(1'b1, 1'b0, b, '0, 10'd7);
        send(1'b0, 1'b1, d, e, 10'd1);
        idle(3);
        checks++; if (err_pulses !== 1) begin errors++; $display("FAIL prot_error_pulses: got %0d, required 1", err_pulses); end
        checks++; if (words_q.size() !== 2) begin errors++; $display("FAIL prot_count: got %0d words, required 2", words_q.size()); end
        if (words_q.size() == 2) begin
            checks++; if (words_q[0] !== w1) begin errors++; $display("FAIL prot_word1: got %h, required %h", words_q[0], w1); end
            checks++; if (words_q[1] !== w2) begin errors++; $display("FAIL prot_word2: got %h, required %h", words_q[1], w2); end
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_mid_reset();
        test_random();
`ifdef AST_UPSIZER_PROT_CHK_EN
        test_prot_chk();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
